// File: rtl/cpu_pkg.sv
// Shared types and sizing constants for the CPU program-memory loader.
// The loader FSM states live here so the bench and any debug logic agree on encoding.
package cpu_pkg;

    localparam int PROG_ADDR_W = 8;
    localparam int INSTR_W     = 16;
    localparam int PROG_DEPTH  = 256;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        LO,
        HI,
        RUN
    } loader_state_t;

endpackage

// File: rtl/program_ram.sv
// Program storage: one synchronous write port, one asynchronous read port, no reset.
// A read of the address being written in the same cycle returns the old word.
module program_ram
    import cpu_pkg::*;
#(
    parameter int ADDR_W = PROG_ADDR_W,
    parameter int DATA_W = INSTR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/program_loader_rom.sv
// Program-memory responder: fills the RAM from a byte stream (length, then low/high byte
// pairs) while holding the CPU in reset, and serves combinational fetches at all times.
module program_loader_rom
    import cpu_pkg::*;
#(
    parameter int ADDR_W = PROG_ADDR_W,
    parameter int DATA_W = INSTR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [7:0]        load_byte,
    output logic              load_ready,
    output logic              load_done,
    output logic              cpu_rst,
    input  logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_value,
    output logic [ADDR_W:0]   word_count
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(1) << ADDR_W;

    loader_state_t     state;
    loader_state_t     next_state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [CNT_W-1:0]  remaining;
    logic [7:0]        lo_latch;

    logic              accept;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic              last_word;
    logic [CNT_W-1:0]  len_words;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == DEPTH) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] decode_len(input logic [7:0] b);
        return (b == 8'd0) ? DEPTH : CNT_W'(b);
    endfunction

    program_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr),
        .wdata (ram_wdata),
        .raddr (mem_address),
        .rdata (mem_value)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // load_start always wins: it restarts from LEN and a coincident byte is dropped
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (load_start) next_state = LEN;
            end
            LEN: begin
                if (load_start)  next_state = LEN;
                else if (accept) next_state = LO;
            end
            LO: begin
                if (load_start)  next_state = LEN;
                else if (accept) next_state = HI;
            end
            HI: begin
                if (load_start)  next_state = LEN;
                else if (accept) next_state = last_word ? RUN : LO;
            end
            RUN: begin
                if (load_start) next_state = LEN;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        accept    = load_valid && load_ready && !load_start;
        ram_we    = (state == HI) && accept;
        ram_wdata = {load_byte, lo_latch};
        last_word = ram_we && (remaining == CNT_W'(1));
        len_words = decode_len(load_byte);
    end

    // cpu_rst drops only on the second RUN cycle, so the CPU sees a reset edge after the last write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            load_ready <= 1'b0;
            cpu_rst    <= 1'b1;
            load_done  <= 1'b0;
        end else begin
            load_ready <= (next_state inside {LEN, LO, HI});
            cpu_rst    <= !((state == RUN) && (next_state == RUN));
            load_done  <= last_word;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            remaining  <= '0;
            lo_latch   <= '0;
            word_count <= '0;
        end else begin
            if ((state == LEN) && accept) begin
                remaining  <= len_words;
                wr_ptr     <= '0;
                word_count <= '0;
            end
            if ((state == LO) && accept) begin
                lo_latch <= load_byte;
            end
            if (ram_we) begin
                wr_ptr     <= wr_ptr + 1'b1;
                word_count <= sat_inc(word_count);
                remaining  <= remaining - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_program_loader_rom.sv
// Scoreboard bench for program_loader_rom: stimulus queues expected read words and
// load_done word counts; a negedge monitor pops and compares when the DUT presents them.
module tb_program_loader_rom;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load_start = 1'b0;
    logic        load_valid = 1'b0;
    logic [7:0]  load_byte = 8'h00;
    logic        load_ready;
    logic        load_done;
    logic        cpu_rst;
    logic [7:0]  mem_address = 8'h00;
    logic [15:0] mem_value;
    logic [8:0]  word_count;

    int checks = 0;
    int errors = 0;

    logic [15:0] rd_q[$];
    logic [8:0]  done_q[$];
    logic        rd_req = 1'b0;
    logic        watch_rst = 1'b0;
    logic        rst_dropped = 1'b0;

    always #5 clk = ~clk;

    program_loader_rom #(
        .ADDR_W (8),
        .DATA_W (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load_start  (load_start),
        .load_valid  (load_valid),
        .load_byte   (load_byte),
        .load_ready  (load_ready),
        .load_done   (load_done),
        .cpu_rst     (cpu_rst),
        .mem_address (mem_address),
        .mem_value   (mem_value),
        .word_count  (word_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares fetch data on read strobes and word_count on every load_done pulse
    always @(negedge clk) begin
        if (rd_req) begin
            if (rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL read_scoreboard: read strobe at addr 0x%0h with no expected word", mem_address);
            end else begin
                check($sformatf("mem_value[0x%0h]", mem_address), 32'(mem_value), 32'(rd_q.pop_front()));
            end
        end
        if (load_done === 1'b1) begin
            if (done_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_load_done: word_count=%0d, expected no pulse", word_count);
            end else begin
                check("word_count_at_done", 32'(word_count), 32'(done_q.pop_front()));
            end
        end
        if (watch_rst && cpu_rst !== 1'b1) begin
            rst_dropped <= 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        load_valid = 1'b0;
        repeat (gap) tick();
        load_valid = 1'b1;
        load_byte  = b;
        n = 0;
        @(negedge clk);
        while (load_ready !== 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (load_ready !== 1'b1) check("load_ready_timeout", 32'(load_ready), 1);
        @(posedge clk);
        #1;
        load_valid = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [15:0] e);
        mem_address = a;
        rd_q.push_back(e);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
    endtask

    initial begin
        logic [7:0] two_word [5];
        two_word = '{8'h02, 8'h02, 8'h05, 8'h02, 8'h10};

        // reset held low, then released with no load
        repeat (3) tick();
        check("rst_cpu_rst", 32'(cpu_rst), 1);
        check("rst_load_ready", 32'(load_ready), 0);
        check("rst_load_done", 32'(load_done), 0);
        check("rst_word_count", 32'(word_count), 0);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_cpu_rst", 32'(cpu_rst), 1);
            check("idle_load_ready", 32'(load_ready), 0);
            check("idle_word_count", 32'(word_count), 0);
        end
        tick();

        // two-word load, valid every cycle
        done_q.push_back(9'd2);
        pulse_start();
        for (int i = 0; i < 5; i++) send_byte(two_word[i], 0);
        check("done_pulse", 32'(load_done), 1);
        check("cpu_rst_first_run_cycle", 32'(cpu_rst), 1);
        tick();
        check("cpu_rst_released", 32'(cpu_rst), 0);
        check("done_one_cycle", 32'(load_done), 0);
        rd(8'd0, 16'h0502);
        rd(8'd1, 16'h1002);

        // full 256-word load, each byte equal to its word address
        done_q.push_back(9'd256);
        pulse_start();
        send_byte(8'h00, 0);
        for (int i = 0; i < 256; i++) begin
            send_byte(8'(i), 0);
            send_byte(8'(i), 0);
        end
        check("word_count_256", 32'(word_count), 256);
        tick();
        check("cpu_rst_after_256", 32'(cpu_rst), 0);
        rd(8'd0, 16'h0000);
        rd(8'd1, 16'h0101);
        rd(8'd128, 16'h8080);
        rd(8'd255, 16'hFFFF);

        // bytes offered in RUN must not be taken
        load_valid = 1'b1;
        load_byte  = 8'h77;
        repeat (5) tick();
        check("run_load_ready", 32'(load_ready), 0);
        check("run_word_count_hold", 32'(word_count), 256);
        load_valid = 1'b0;
        rd(8'd0, 16'h0000);

        // same two-word stream with random valid gaps
        done_q.push_back(9'd2);
        pulse_start();
        for (int i = 0; i < 5; i++) send_byte(two_word[i], int'($urandom_range(0, 3)));
        tick();
        check("cpu_rst_after_random", 32'(cpu_rst), 0);
        rd(8'd0, 16'h0502);
        rd(8'd1, 16'h1002);
        rd(8'd2, 16'h0202);

        // abort a 4-word load after 3 bytes, start coincident with a byte, then a 1-word load
        pulse_start();
        watch_rst = 1'b1;
        send_byte(8'h04, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        rd(8'd0, 16'h2211);
        load_valid = 1'b1;
        load_byte  = 8'h33;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        load_valid = 1'b0;
        done_q.push_back(9'd1);
        send_byte(8'h01, 0);
        send_byte(8'hCD, 0);
        send_byte(8'hAB, 0);
        watch_rst = 1'b0;
        check("cpu_rst_held_through_abort", 32'(rst_dropped), 0);
        check("word_count_after_abort", 32'(word_count), 1);
        rd(8'd0, 16'hABCD);
        rd(8'd1, 16'h1002);

        // reset pulled low while in HI with a latched low byte
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h44, 0);
        send_byte(8'h33, 0);
        send_byte(8'h55, 0);
        check("pre_rst_load_ready", 32'(load_ready), 1);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_load_ready", 32'(load_ready), 0);
        check("async_rst_cpu_rst", 32'(cpu_rst), 1);
        check("async_rst_word_count", 32'(word_count), 0);
        check("async_rst_load_done", 32'(load_done), 0);
        rd(8'd0, 16'h3344);
        rd(8'd1, 16'h1002);
        rst = 1'b1;
        load_valid = 1'b1;
        load_byte  = 8'h66;
        repeat (10) tick();
        check("post_rst_idle_ready", 32'(load_ready), 0);
        check("post_rst_word_count", 32'(word_count), 0);
        check("post_rst_cpu_rst", 32'(cpu_rst), 1);
        load_valid = 1'b0;
        rd(8'd0, 16'h3344);
        rd(8'd1, 16'h1002);
        tick();

        check("missing_load_done", 32'(done_q.size()), 0);
        check("missing_reads", 32'(rd_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit with %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
